// File: rtl/mem_pkg.sv
// Shared encodings for the memory-channel stimulus serializer: target codes,
// channel state codes and per-channel beat geometry.
package mem_pkg;

  localparam logic [1:0] TGT_SDRAM = 2'd0;
  localparam logic [1:0] TGT_FLASH = 2'd1;
  localparam logic [1:0] TGT_ROM   = 2'd2;
  localparam logic [1:0] TGT_NONE  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam int SDRAM_BEATS = 2;
  localparam int FLASH_BEATS = 1;
  localparam int ROM_BEATS   = 4;

  localparam int SDRAM_CHUNK_W = 4;
  localparam int FLASH_CHUNK_W = 8;
  localparam int ROM_CHUNK_W   = 2;

  localparam int SDRAM_OUT_W = 4;
  localparam int FLASH_OUT_W = 8;
  localparam int ROM_OUT_W   = 3;

endpackage

// File: rtl/mem_src_chan.sv
// One serializer channel: latches a byte, then emits it LSB-chunk first as
// BEATS valid/ready beats of CHUNK_W bits, zero-extended to OUT_W.
module mem_src_chan
  import mem_pkg::*;
#(
  parameter int BEATS   = 2,
  parameter int CHUNK_W = 4,
  parameter int OUT_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             accept_i,
  input  logic [7:0]       data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output logic             busy_o
);

  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
  localparam logic [7:0] CHUNK_MASK = 8'((1 << CHUNK_W) - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       buf_q, buf_d;

  function automatic logic [OUT_W-1:0] sel_beat(input logic [7:0] b,
                                                input logic [IDX_W-1:0] k);
    logic [7:0] chunk;
    chunk = (b >> (CHUNK_W * int'(k))) & CHUNK_MASK;
    return OUT_W'(chunk);
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (state_q == ST_IDLE) begin
      if (accept_i) begin
        buf_d   = data_i;
        idx_d   = '0;
        state_d = ST_SEND;
      end
    end else if (ready_i) begin
      // The last-beat edge always leaves at least one IDLE cycle before reuse.
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  assign busy_o  = (state_q == ST_SEND);
  assign valid_o = busy_o;
  assign data_o  = busy_o ? sel_beat(buf_q, idx_q) : '0;

endmodule

// File: rtl/mem_src.sv
// Stimulus-side serializer: routes tagged bytes to three concurrent channel
// serializers (SDRAM nibbles, flash bytes, ROM 2-bit chunks).
module mem_src
  import mem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] in_target,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       sdram_valid,
  output logic [3:0] sdram_data_o,
  input  logic       sdram_ready,
  output logic       flash_valid,
  output logic [7:0] flash_data_o,
  input  logic       flash_ready,
  output logic       rom_valid,
  output logic [2:0] rom_data_o,
  input  logic       rom_ready,
  output logic       drop,
  output logic [2:0] busy
);

  logic tgt_free;
  logic accept;
  logic sdram_busy, flash_busy, rom_busy;
  logic drop_q;

  // in_ready looks at pre-edge state, so a last-beat edge cannot also accept.
  always_comb begin
    tgt_free = 1'b1;
    case (in_target)
      TGT_SDRAM: tgt_free = !sdram_busy;
      TGT_FLASH: tgt_free = !flash_busy;
      TGT_ROM:   tgt_free = !rom_busy;
      default:   tgt_free = 1'b1;
    endcase
  end

  assign in_ready = !reset && tgt_free;
  assign accept   = in_valid && in_ready;

  mem_src_chan #(
    .BEATS  (SDRAM_BEATS),
    .CHUNK_W(SDRAM_CHUNK_W),
    .OUT_W  (SDRAM_OUT_W)
  ) u_sdram (
    .clk_i   (clock),
    .rst_i   (reset),
    .accept_i(accept && (in_target == TGT_SDRAM)),
    .data_i  (in_data),
    .ready_i (sdram_ready),
    .valid_o (sdram_valid),
    .data_o  (sdram_data_o),
    .busy_o  (sdram_busy)
  );

  mem_src_chan #(
    .BEATS  (FLASH_BEATS),
    .CHUNK_W(FLASH_CHUNK_W),
    .OUT_W  (FLASH_OUT_W)
  ) u_flash (
    .clk_i   (clock),
    .rst_i   (reset),
    .accept_i(accept && (in_target == TGT_FLASH)),
    .data_i  (in_data),
    .ready_i (flash_ready),
    .valid_o (flash_valid),
    .data_o  (flash_data_o),
    .busy_o  (flash_busy)
  );

  mem_src_chan #(
    .BEATS  (ROM_BEATS),
    .CHUNK_W(ROM_CHUNK_W),
    .OUT_W  (ROM_OUT_W)
  ) u_rom (
    .clk_i   (clock),
    .rst_i   (reset),
    .accept_i(accept && (in_target == TGT_ROM)),
    .data_i  (in_data),
    .ready_i (rom_ready),
    .valid_o (rom_valid),
    .data_o  (rom_data_o),
    .busy_o  (rom_busy)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= accept && (in_target == TGT_NONE);
  end

  assign drop = drop_q;
  assign busy = {rom_busy, flash_busy, sdram_busy};

endmodule

// File: tb/tb_mem_src.sv
// Directed bench for mem_src: a per-cycle vector table plus hand sequences
// for reset behaviour, asynchronous mid-byte reset and ROM reconstruction.
module tb_mem_src;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_target = 2'd0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       sdram_valid;
  logic [3:0] sdram_data_o;
  logic       sdram_ready = 1'b0;
  logic       flash_valid;
  logic [7:0] flash_data_o;
  logic       flash_ready = 1'b0;
  logic       rom_valid;
  logic [2:0] rom_data_o;
  logic       rom_ready = 1'b0;
  logic       drop;
  logic [2:0] busy;

  int n_pass = 0;
  int n_total = 0;

  mem_src dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_target   (in_target),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .sdram_valid (sdram_valid),
    .sdram_data_o(sdram_data_o),
    .sdram_ready (sdram_ready),
    .flash_valid (flash_valid),
    .flash_data_o(flash_data_o),
    .flash_ready (flash_ready),
    .rom_valid   (rom_valid),
    .rom_data_o  (rom_data_o),
    .rom_ready   (rom_ready),
    .drop        (drop),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic [1:0] tgt;
    logic [7:0] din;
    logic       rs;
    logic       fr;
    logic       rr;
    logic       e_rdy;
    logic       e_sv;
    logic [3:0] e_sd;
    logic       e_fv;
    logic [7:0] e_fd;
    logic       e_rv;
    logic [2:0] e_rd;
    logic       e_drop;
    logic [2:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic iv, input logic [1:0] tgt, input logic [7:0] din,
                              input logic rs, input logic fr, input logic rr,
                              input logic e_rdy, input logic e_sv, input logic [3:0] e_sd,
                              input logic e_fv, input logic [7:0] e_fd,
                              input logic e_rv, input logic [2:0] e_rd,
                              input logic e_drop, input logic [2:0] e_busy);
    vec_t v;
    v.iv = iv; v.tgt = tgt; v.din = din; v.rs = rs; v.fr = fr; v.rr = rr;
    v.e_rdy = e_rdy; v.e_sv = e_sv; v.e_sd = e_sd; v.e_fv = e_fv; v.e_fd = e_fd;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_drop = e_drop; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".in_ready"},    32'(in_ready),     32'(v.e_rdy));
    chk({tag, ".sdram_valid"}, 32'(sdram_valid),  32'(v.e_sv));
    chk({tag, ".sdram_data"},  32'(sdram_data_o), 32'(v.e_sd));
    chk({tag, ".flash_valid"}, 32'(flash_valid),  32'(v.e_fv));
    chk({tag, ".flash_data"},  32'(flash_data_o), 32'(v.e_fd));
    chk({tag, ".rom_valid"},   32'(rom_valid),    32'(v.e_rv));
    chk({tag, ".rom_data"},    32'(rom_data_o),   32'(v.e_rd));
    chk({tag, ".drop"},        32'(drop),         32'(v.e_drop));
    chk({tag, ".busy"},        32'(busy),         32'(v.e_busy));
  endtask

  initial begin
    logic [7:0] recon;
    int         beats_seen;

    //        iv tgt  din   rs fr rr | rdy sv sd   fv fd     rv rd    drop busy
    // SDRAM A5: nibbles 5 then A, two cycles
    vecs.push_back(mk(1, 0, 8'hA5, 1, 1, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 4'h5, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 4'hA, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    // ROM C6: 010, 001, 000, 011
    vecs.push_back(mk(1, 2, 8'hC6, 1, 1, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    vecs.push_back(mk(0, 2, 8'h00, 1, 1, 1, 0, 0, 4'h0, 0, 8'h00, 1, 3'b010, 0, 3'b100));
    vecs.push_back(mk(0, 2, 8'h00, 1, 1, 1, 0, 0, 4'h0, 0, 8'h00, 1, 3'b001, 0, 3'b100));
    vecs.push_back(mk(0, 2, 8'h00, 1, 1, 1, 0, 0, 4'h0, 0, 8'h00, 1, 3'b000, 0, 3'b100));
    vecs.push_back(mk(0, 2, 8'h00, 1, 1, 1, 0, 0, 4'h0, 0, 8'h00, 1, 3'b011, 0, 3'b100));
    // Flash 3C with ready low 3 cycles: held 4 cycles
    vecs.push_back(mk(1, 1, 8'h3C, 1, 0, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 1, 0, 0, 4'h0, 1, 8'h3C, 0, 3'd0, 0, 3'b010));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 1, 0, 0, 4'h0, 1, 8'h3C, 0, 3'd0, 0, 3'b010));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 1, 0, 0, 4'h0, 1, 8'h3C, 0, 3'd0, 0, 3'b010));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 0, 0, 4'h0, 1, 8'h3C, 0, 3'd0, 0, 3'b010));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    // SDRAM stalled; same-channel request blocked, flash request accepted
    vecs.push_back(mk(1, 0, 8'h5A, 0, 0, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    vecs.push_back(mk(1, 0, 8'h77, 0, 0, 1, 0, 1, 4'hA, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    vecs.push_back(mk(1, 1, 8'h77, 0, 0, 1, 1, 1, 4'hA, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 1, 4'hA, 1, 8'h77, 0, 3'd0, 0, 3'b011));
    // Target 3 drop while both channels drain
    vecs.push_back(mk(1, 3, 8'hFF, 1, 1, 1, 1, 1, 4'hA, 1, 8'h77, 0, 3'd0, 0, 3'b011));
    vecs.push_back(mk(0, 3, 8'h00, 1, 1, 1, 1, 1, 4'h5, 0, 8'h00, 0, 3'd0, 1, 3'b001));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    // Last-beat edge with a pending request: not accepted until next edge
    vecs.push_back(mk(1, 0, 8'h12, 1, 1, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    vecs.push_back(mk(1, 0, 8'h34, 1, 1, 1, 0, 1, 4'h2, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    vecs.push_back(mk(1, 0, 8'h34, 1, 1, 1, 0, 1, 4'h1, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    vecs.push_back(mk(1, 0, 8'h34, 1, 1, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 4'h4, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 1, 4'h3, 0, 8'h00, 0, 3'd0, 0, 3'b001));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));

    // Reset held: everything quiet, in_ready low even with a request present
    in_valid = 1'b1; in_target = 2'd3; sdram_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_all("reset", mk(1, 3, 8'h00, 1, 0, 0, 0, 0, 4'h0, 0, 8'h00, 0, 3'd0, 0, 3'b000));
    in_valid = 1'b0;
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      in_valid = vecs[i].iv; in_target = vecs[i].tgt; in_data = vecs[i].din;
      sdram_ready = vecs[i].rs; flash_ready = vecs[i].fr; rom_ready = vecs[i].rr;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset between ROM beats 1 and 2
    @(negedge clock);
    in_valid = 1'b1; in_target = 2'd2; in_data = 8'hFF; rom_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    #1 chk("arst.pre_beat0", 32'(rom_data_o), 32'h3);
    @(negedge clock);
    @(negedge clock);
    #1 chk("arst.pre_beat2_valid", 32'(rom_valid), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("arst.rom_valid", 32'(rom_valid), 32'h0);
    chk("arst.rom_data", 32'(rom_data_o), 32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.in_ready", 32'(in_ready), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      #1;
      chk("arst.no_residual_valid", 32'(rom_valid), 32'h0);
      chk("arst.no_residual_data", 32'(rom_data_o), 32'h0);
    end

    // New ROM byte after reset: starts at beat 0 and reassembles to 9B
    in_valid = 1'b1; in_target = 2'd2; in_data = 8'h9B;
    @(negedge clock);
    in_valid = 1'b0;
    recon = 8'h00;
    beats_seen = 0;
    #1 chk("rom2.first_beat", 32'(rom_data_o), 32'h3);
    for (int k = 0; k < 8 && beats_seen < 4; k++) begin
      if (rom_valid) begin
        recon = recon | (8'(rom_data_o[1:0]) << (2 * beats_seen));
        beats_seen++;
      end
      @(negedge clock);
      #1;
    end
    chk("rom2.beats", 32'(beats_seen), 32'd4);
    chk("rom2.recon", 32'(recon), 32'h9B);
    chk("rom2.idle_after", 32'(rom_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
